// File: rtl/downscale_engine.sv
// 2x2 box-filter downscaler driving a single-port RAM (8-bit pixels, 4 per word).
// Build option: define DS_ROUND_EN for round-half-up averaging; otherwise the average truncates.

module ds_avg4 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] c,
  input  logic [7:0] d,
  output logic [7:0] avg
);
  logic [9:0] sum;
  assign sum = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
`ifdef DS_ROUND_EN
  logic [9:0] rnd;
  assign rnd = sum + 10'd2;
  assign avg = rnd[9:2];
`else
  assign avg = sum[9:2];
`endif
endmodule

module downscale_engine (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] src_base,
  input  logic [15:0] dst_base,
  input  logic [7:0]  img_w_words,
  input  logic [8:0]  img_h,
  output logic        busy,
  output logic        done,
  output logic        o_mem_we,
  output logic [3:0]  o_mem_byte_en,
  output logic [15:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata
);
  localparam int NUM_LANES = 2;

  typedef enum logic [2:0] {IDLE, RD_TOP, RD_BOT, CAP_BOT, WR, DONE} state_t;

  state_t      state, next;
  logic [7:0]  w_q, h2_q, col, row;
  logic [15:0] stride_q, top_ptr, dst_ptr, top_nxt, dst_nxt;
  logic [31:0] top_q;
  logic        last_col, last_row;

  logic [NUM_LANES-1:0][7:0] pix;

  logic        busy_d, done_d, we_d;
  logic [3:0]  be_d;
  logic [15:0] addr_d;
  logic [31:0] wdata_d;

  // Lane g averages bytes 2g,2g+1 of the top and bottom words; the bottom word is
  // consumed straight off the read bus so the result lands in the WR cycle.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    ds_avg4 u_avg (
      .a   (top_q[16*g +: 8]),
      .b   (top_q[16*g+8 +: 8]),
      .c   (i_mem_rdata[16*g +: 8]),
      .d   (i_mem_rdata[16*g+8 +: 8]),
      .avg (pix[g])
    );
  end

  assign last_col = (col == w_q - 8'd1);
  assign last_row = (row == h2_q - 8'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (start) next = (img_w_words == 8'd0 || img_h < 9'd2) ? DONE : RD_TOP;
      RD_TOP:  next = RD_BOT;
      RD_BOT:  next = CAP_BOT;
      CAP_BOT: next = WR;
      WR:      next = (last_col && last_row) ? DONE : RD_TOP;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Walk pointers instead of multiplying: the top pointer skips the bottom row
  // at the end of each row pair, the destination advances 2 bytes per column.
  always_comb begin
    top_nxt = top_ptr;
    dst_nxt = dst_ptr;
    if (state == IDLE) begin
      top_nxt = src_base & 16'hFFFC;
      dst_nxt = dst_base & 16'hFFFC;
    end else if (state == WR) begin
      top_nxt = top_ptr + (last_col ? stride_q + 16'd4 : 16'd4);
      dst_nxt = dst_ptr + 16'd2;
    end
  end

  always_comb begin
    busy_d  = (next == RD_TOP) || (next == RD_BOT) || (next == CAP_BOT) || (next == WR);
    done_d  = (next == DONE);
    we_d    = (next == WR);
    be_d    = 4'b0000;
    addr_d  = 16'h0000;
    wdata_d = 32'h0;
    case (next)
      RD_TOP:  addr_d = top_nxt;
      RD_BOT:  addr_d = o_mem_addr + stride_q;
      CAP_BOT: addr_d = o_mem_addr;
      WR: begin
        addr_d  = dst_ptr & 16'hFFFC;
        be_d    = dst_ptr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {pix, pix};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      o_mem_we      <= 1'b0;
      o_mem_byte_en <= 4'b0;
      o_mem_addr    <= 16'h0;
      o_mem_wdata   <= 32'h0;
      w_q           <= 8'd0;
      h2_q          <= 8'd0;
      stride_q      <= 16'h0;
      top_ptr       <= 16'h0;
      dst_ptr       <= 16'h0;
      col           <= 8'd0;
      row           <= 8'd0;
      top_q         <= 32'h0;
    end else begin
      busy          <= busy_d;
      done          <= done_d;
      o_mem_we      <= we_d;
      o_mem_byte_en <= be_d;
      o_mem_addr    <= addr_d;
      o_mem_wdata   <= wdata_d;
      top_ptr       <= top_nxt;
      dst_ptr       <= dst_nxt;
      if (state == IDLE) begin
        w_q      <= img_w_words;
        h2_q     <= img_h[8:1];
        stride_q <= {6'b0, img_w_words, 2'b00};
        col      <= 8'd0;
        row      <= 8'd0;
      end else if (state == WR) begin
        col <= last_col ? 8'd0 : col + 8'd1;
        row <= row + {7'd0, last_col};
      end
      if (state == RD_BOT) top_q <= i_mem_rdata;
    end
  end
endmodule

// File: tb/tb_downscale_engine.sv
// Directed bench for downscale_engine: table of single-word jobs plus sequences
// for multi-column ordering, ignored starts and mid-job reset.
module tb_downscale_engine;
  logic        clk, rst_n, start;
  logic [15:0] src_base, dst_base;
  logic [7:0]  img_w_words;
  logic [8:0]  img_h;
  logic        busy, done, o_mem_we;
  logic [3:0]  o_mem_byte_en;
  logic [15:0] o_mem_addr;
  logic [31:0] o_mem_wdata, i_mem_rdata;

  downscale_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_base(src_base), .dst_base(dst_base),
    .img_w_words(img_w_words), .img_h(img_h), .busy(busy), .done(done),
    .o_mem_we(o_mem_we), .o_mem_byte_en(o_mem_byte_en), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source RAM: written only by the stimulus process, read with one-cycle latency.
  logic [31:0] mem [0:16383];
  always @(posedge clk) i_mem_rdata <= mem[o_mem_addr[15:2]];

  typedef struct {
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } wr_t;

  typedef struct {
    logic [15:0] src, dst;
    logic [7:0]  w;
    logic [8:0]  h;
    logic [31:0] top, bot;
    int          exp_done, exp_nwr;
    logic [15:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
  } vec_t;

`ifdef DS_ROUND_EN
  localparam logic [31:0] RND_WD = 32'h00020002;
`else
  localparam logic [31:0] RND_WD = 32'h00010001;
`endif

  wr_t          wq[$];
  logic [15:0]  rq[$];
  int           done_cyc, busy_bad;
  int           n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic mem_clear();
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
    chk({tag, "_we"}, {31'd0, o_mem_we}, 0);
    chk({tag, "_be"}, {28'd0, o_mem_byte_en}, 0);
    chk({tag, "_addr"}, {16'd0, o_mem_addr}, 0);
    chk({tag, "_wdata"}, o_mem_wdata, 0);
  endtask

  // Runs one job; k counts cycles after the edge that sampled start.
  task automatic run_job(input logic [15:0] src, input logic [15:0] dst, input logic [7:0] w,
                         input logic [8:0] h, input int exp_done, input int inj, input int rst_at);
    bit fin;
    wq.delete(); rq.delete();
    done_cyc = -1; busy_bad = 0; fin = 0;
    @(negedge clk);
    src_base = src; dst_base = dst; img_w_words = w; img_h = h; start = 1'b1;
    for (int k = 1; k <= 2000 && !fin; k++) begin
      @(negedge clk);
      if (o_mem_we) wq.push_back('{o_mem_addr, o_mem_byte_en, o_mem_wdata});
      else if (busy) rq.push_back(o_mem_addr);
      if (!o_mem_we && o_mem_byte_en != 4'b0) busy_bad++;
      if (rst_at == 0 && busy !== (k < exp_done)) busy_bad++;
      start = (k == inj);
      if (k == inj) begin
        src_base = 16'h2000; dst_base = 16'h0F00; img_w_words = 8'd7; img_h = 9'd9;
      end
      if (done) begin done_cyc = k; fin = 1; end
      if (rst_at > 0 && k == rst_at) rst_n = 1'b0;
      if (rst_at > 0 && k == rst_at + 1) begin
        chk_idle_outputs("rst_mid");
        rst_n = 1'b1;
        fin = 1;
      end
    end
    chk("job_finished", {31'd0, fin}, 1);
    start = 1'b0;
  endtask

  task automatic idle_window(output int ev);
    ev = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      ev += int'(done) + int'(busy) + int'(o_mem_we);
    end
  endtask

  vec_t vt[7];

  initial begin
    int ev;
    rst_n = 1'b0; start = 1'b0; src_base = 16'h0; dst_base = 16'h0;
    img_w_words = 8'd0; img_h = 9'd0;
    mem_clear();
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst_n = 1'b1;

    vt[0] = '{16'h0000, 16'h0100, 8'd1, 9'd2, 32'h40302010, 32'h80706050, 5, 1, 16'h0100, 4'b0011, 32'h58385838};
    vt[1] = '{16'h0400, 16'h0300, 8'd1, 9'd2, 32'h00000101, 32'h00000202, 5, 1, 16'h0300, 4'b0011, RND_WD};
    vt[2] = '{16'h0500, 16'h0603, 8'd1, 9'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 1, 16'h0600, 4'b0011, 32'hFFFFFFFF};
    vt[3] = '{16'h0000, 16'h0100, 8'd4, 9'd1, 32'h11111111, 32'h22222222, 1, 0, 16'h0000, 4'b0000, 32'h0};
    vt[4] = '{16'h0000, 16'h0100, 8'd0, 9'd4, 32'h11111111, 32'h22222222, 1, 0, 16'h0000, 4'b0000, 32'h0};
    vt[5] = '{16'hFFFC, 16'h0700, 8'd1, 9'd2, 32'h04040404, 32'h08080808, 5, 1, 16'h0700, 4'b0011, 32'h06060606};
    vt[6] = '{16'h0800, 16'h0900, 8'd1, 9'd3, 32'h10101010, 32'h30303030, 5, 1, 16'h0900, 4'b0011, 32'h20202020};

    for (int i = 0; i < 7; i++) begin
      logic [15:0] bot_a;
      mem_clear();
      bot_a = vt[i].src + {6'd0, vt[i].w, 2'b00};
      mem[vt[i].src[15:2]] = vt[i].top;
      mem[bot_a[15:2]] = vt[i].bot;
      run_job(vt[i].src, vt[i].dst, vt[i].w, vt[i].h, vt[i].exp_done, 0, 0);
      chk($sformatf("v%0d_done_cyc", i), done_cyc, vt[i].exp_done);
      chk($sformatf("v%0d_nwr", i), wq.size(), vt[i].exp_nwr);
      chk($sformatf("v%0d_busy_be", i), busy_bad, 0);
      if (vt[i].exp_nwr > 0 && wq.size() > 0) begin
        chk($sformatf("v%0d_addr", i), {16'd0, wq[0].addr}, {16'd0, vt[i].exp_addr});
        chk($sformatf("v%0d_be", i), {28'd0, wq[0].be}, {28'd0, vt[i].exp_be});
        chk($sformatf("v%0d_wdata", i), wq[0].wd, vt[i].exp_wd);
      end
      if (vt[i].exp_nwr == 0) chk($sformatf("v%0d_no_access", i), rq.size(), 0);
      if (i == 5) begin
        bit saw_top, saw_bot;
        saw_top = 0; saw_bot = 0;
        foreach (rq[j]) begin
          if (rq[j] == 16'hFFFC) saw_top = 1;
          if (rq[j] == 16'h0000) saw_bot = 1;
        end
        chk("wrap_top_read", {31'd0, saw_top}, 1);
        chk("wrap_bot_read", {31'd0, saw_bot}, 1);
      end
    end

    // 3 words x 5 rows: word (x,y) holds bytes 16y+4x, so output (r,c) is 32r+4c+8.
    begin
      logic [15:0] ea [6];
      logic [3:0]  eb [6];
      bit          row4;
      ea = '{16'h0200, 16'h0200, 16'h0204, 16'h0204, 16'h0208, 16'h0208};
      eb = '{4'b0011, 4'b1100, 4'b0011, 4'b1100, 4'b0011, 4'b1100};
      mem_clear();
      for (int y = 0; y < 5; y++)
        for (int x = 0; x < 3; x++)
          mem[1024 + y*3 + x] = {4{8'(16*y + 4*x)}};
      run_job(16'h1000, 16'h0200, 8'd3, 9'd5, 25, 0, 0);
      chk("multi_done_cyc", done_cyc, 25);
      chk("multi_nwr", wq.size(), 6);
      chk("multi_busy_be", busy_bad, 0);
      for (int i = 0; i < 6 && i < wq.size(); i++) begin
        chk($sformatf("multi_addr%0d", i), {16'd0, wq[i].addr}, {16'd0, ea[i]});
        chk($sformatf("multi_be%0d", i), {28'd0, wq[i].be}, {28'd0, eb[i]});
        chk($sformatf("multi_wd%0d", i), wq[i].wd, {4{8'(32*(i/3) + 4*(i%3) + 8)}});
      end
      row4 = 0;
      foreach (rq[j]) if (rq[j] >= 16'h1030 && rq[j] <= 16'h1038) row4 = 1;
      chk("multi_row4_unread", {31'd0, row4}, 0);
    end

    // Start with new parameters while busy, then while in DONE: both ignored.
    for (int t = 0; t < 2; t++) begin
      mem_clear();
      mem[0] = 32'h40302010; mem[1] = 32'h80706050;
      run_job(16'h0000, 16'h0100, 8'd1, 9'd2, 5, (t == 0) ? 2 : 5, 0);
      chk($sformatf("ign%0d_done_cyc", t), done_cyc, 5);
      chk($sformatf("ign%0d_nwr", t), wq.size(), 1);
      if (wq.size() > 0) begin
        chk($sformatf("ign%0d_addr", t), {16'd0, wq[0].addr}, 32'h0100);
        chk($sformatf("ign%0d_wdata", t), wq[0].wd, 32'h58385838);
      end
      idle_window(ev);
      chk($sformatf("ign%0d_quiet_after", t), ev, 0);
    end

    // Reset during RD_BOT (cycle 2), then a clean job.
    mem_clear();
    mem[0] = 32'h40302010; mem[1] = 32'h80706050;
    run_job(16'h0000, 16'h0100, 8'd3, 9'd5, 0, 0, 2);
    chk("rst_no_writes", wq.size(), 0);
    idle_window(ev);
    chk("rst_stays_idle", ev, 0);
    run_job(16'h0000, 16'h0100, 8'd1, 9'd2, 5, 0, 0);
    chk("post_rst_done_cyc", done_cyc, 5);
    chk("post_rst_nwr", wq.size(), 1);
    if (wq.size() > 0) chk("post_rst_wdata", wq[0].wd, 32'h58385838);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
